// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock pointer/flag controller for a FIFO memory array
// whose depth does not have to be a power of two. It gates push/pop into
// memory enables, advances the wrapping pointers, tracks occupancy and
// registered flags, and keeps sticky overflow/underflow bits.
module fifo_ctrl #(
  parameter int S        = 8,
  parameter int DEPTH    = 150,
  parameter int AF_LEVEL = 146,
  parameter int AE_LEVEL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic         clr_err,
  output logic         mem_wr_en,
  output logic         mem_rd_en,
  output logic [S-1:0] wr_ptr,
  output logic [S-1:0] rd_ptr,
  output logic         fifo_full,
  output logic         fifo_empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [S:0]   fifo_count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [S-1:0] LAST_PTR = S'(DEPTH - 1);
  localparam logic [S:0]   DEPTH_C  = (S+1)'(DEPTH);
  localparam logic [S:0]   AF_C     = (S+1)'(AF_LEVEL);
  localparam logic [S:0]   AE_C     = (S+1)'(AE_LEVEL);
  localparam logic [S:0]   ONE_C    = (S+1)'(1);

  logic         wr_acc, rd_acc;
  logic [S-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [S:0]   count_nxt;

  // Accept gating: a full FIFO rejects push and an empty FIFO rejects pop
  // even when the opposite operation arrives in the same cycle, because the
  // flags are registered and the memory gates on them the same way.
  assign wr_acc    = push & ~fifo_full  & ~flush;
  assign rd_acc    = pop  & ~fifo_empty & ~flush;
  assign mem_wr_en = wr_acc;
  assign mem_rd_en = rd_acc;

  // Next-state pointers and count; flush overrides everything.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = fifo_count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (wr_acc) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      // The accept gating keeps the count inside 0..DEPTH.
      if (wr_acc && !rd_acc)      count_nxt = fifo_count + ONE_C;
      else if (rd_acc && !wr_acc) count_nxt = fifo_count - ONE_C;
    end
  end

  // Pointer, count and flag registers; flags come from the next count so
  // they line up with the count they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      fifo_count   <= count_nxt;
      fifo_full    <= (count_nxt == DEPTH_C);
      fifo_empty   <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
    end
  end

  // Sticky error bits: a new error in the clear cycle wins over the clear;
  // flush suppresses error detection but never clears the bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (push & fifo_full  & ~flush) | (overflow  & ~clr_err);
      underflow <= (pop  & fifo_empty & ~flush) | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a table of directed single-cycle
// vectors, then hand-written fill / wrap-read / simultaneous / flush /
// async-reset sequences with a small memory array on the pointers.
module tb_fifo_ctrl;
  localparam int S = 8;
  localparam int DEPTH = 150;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push, pop, flush, clr_err;
  logic         mem_wr_en, mem_rd_en;
  logic [S-1:0] wr_ptr, rd_ptr;
  logic         fifo_full, fifo_empty, almost_full, almost_empty;
  logic [S:0]   fifo_count;
  logic         overflow, underflow;

  fifo_ctrl #(.S(S), .DEPTH(DEPTH), .AF_LEVEL(146), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_count(fifo_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Memory array driven by the DUT's enables and pointers.
  logic [7:0] mem [DEPTH];
  logic [7:0] wdata;
  logic [7:0] rd_data;
  always @(posedge clk) begin
    if (mem_wr_en) mem[wr_ptr] <= wdata;
    if (mem_rd_en) rd_data <= mem[rd_ptr];
  end

  int n_chk = 0;
  int n_fail = 0;
  logic s_wen, s_ren;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample enables before the edge, then
  // leave the bench 1 time unit after the posedge for registered checks.
  task automatic cyc(input logic p, input logic q, input logic f, input logic c);
    @(negedge clk);
    push = p; pop = q; flush = f; clr_err = c;
    #1;
    s_wen = mem_wr_en;
    s_ren = mem_rd_en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string nm, input int cnt, input logic full,
                           input logic empty, input logic af, input logic ae);
    chk({nm, ".count"}, 32'(fifo_count), cnt);
    chk({nm, ".full"}, 32'(fifo_full), 32'(full));
    chk({nm, ".empty"}, 32'(fifo_empty), 32'(empty));
    chk({nm, ".af"}, 32'(almost_full), 32'(af));
    chk({nm, ".ae"}, 32'(almost_empty), 32'(ae));
  endtask

  typedef struct {
    logic push, pop, flush, clr;
    logic wen, ren;
    int   cnt, wp, rp;
    logic full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t v[11];

  initial begin
    //        push pop fl clr wen ren cnt wp rp full emp af ae ovf unf
    v[0]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
    v[1]  = '{1, 0, 0, 0, 1, 0, 2, 2, 0, 0, 0, 0, 1, 0, 0};
    v[2]  = '{0, 1, 0, 0, 0, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0};
    v[3]  = '{1, 1, 0, 0, 1, 1, 1, 3, 2, 0, 0, 0, 1, 0, 0};
    v[4]  = '{0, 1, 0, 0, 0, 1, 0, 3, 3, 0, 1, 0, 1, 0, 0};
    v[5]  = '{0, 1, 0, 0, 0, 0, 0, 3, 3, 0, 1, 0, 1, 0, 1};
    v[6]  = '{1, 1, 0, 0, 1, 0, 1, 4, 3, 0, 0, 0, 1, 0, 1};
    v[7]  = '{0, 0, 0, 1, 0, 0, 1, 4, 3, 0, 0, 0, 1, 0, 0};
    v[8]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    v[9]  = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
    v[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0};

    push = 0; pop = 0; flush = 0; clr_err = 0; wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_flags("reset", 0, 0, 1, 0, 1);
    chk("reset.wr_ptr", 32'(wr_ptr), 0);
    chk("reset.rd_ptr", 32'(rd_ptr), 0);
    chk("reset.ovf", 32'(overflow), 0);
    chk("reset.unf", 32'(underflow), 0);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc(v[i].push, v[i].pop, v[i].flush, v[i].clr);
      chk({nm, ".wen"}, 32'(s_wen), 32'(v[i].wen));
      chk({nm, ".ren"}, 32'(s_ren), 32'(v[i].ren));
      chk({nm, ".wr_ptr"}, 32'(wr_ptr), v[i].wp);
      chk({nm, ".rd_ptr"}, 32'(rd_ptr), v[i].rp);
      chk({nm, ".ovf"}, 32'(overflow), 32'(v[i].ovf));
      chk({nm, ".unf"}, 32'(underflow), 32'(v[i].unf));
      chk_flags(nm, v[i].cnt, v[i].full, v[i].empty, v[i].af, v[i].ae);
    end

    // Fill 150 entries with data 0..149 from an empty FIFO at pointer 0.
    for (int i = 0; i < DEPTH; i++) begin
      wdata = 8'(i);
      cyc(1, 0, 0, 0);
      if (i == 144 || i == 145 || i == 148 || i == 149 || i == 3 || i == 4) begin
        chk_flags($sformatf("fill%0d", i + 1), i + 1, (i + 1) == DEPTH, 0,
                  (i + 1) >= 146, (i + 1) <= 4);
      end else begin
        chk($sformatf("fill%0d.count", i + 1), 32'(fifo_count), i + 1);
      end
    end
    chk("fill.wr_ptr_wrap", 32'(wr_ptr), 0);
    chk("fill.ovf_before", 32'(overflow), 0);

    // 151st push is rejected and flags overflow.
    wdata = 8'hEE;
    cyc(1, 0, 0, 0);
    chk("over.wen", 32'(s_wen), 0);
    chk("over.ovf", 32'(overflow), 1);
    chk_flags("over", 150, 1, 0, 1, 0);

    // Push+pop while full: only the pop goes through.
    cyc(1, 1, 0, 0);
    chk("fullpp.wen", 32'(s_wen), 0);
    chk("fullpp.ren", 32'(s_ren), 1);
    chk("fullpp.data", 32'(rd_data), 0);
    chk("fullpp.rd_ptr", 32'(rd_ptr), 1);
    chk_flags("fullpp", 149, 0, 0, 1, 0);

    // Read back the remaining entries in push order.
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 1, 0, 0);
      chk($sformatf("rd%0d.data", i), 32'(rd_data), i);
      if (i == 149) chk("rd149.rd_ptr_pre", 32'(s_ren), 1);
    end
    chk("rd.rd_ptr_wrap", 32'(rd_ptr), 0);
    chk_flags("drained", 0, 0, 1, 0, 1);

    // Extra pop on empty.
    cyc(0, 1, 0, 0);
    chk("under.ren", 32'(s_ren), 0);
    chk("under.unf", 32'(underflow), 1);
    chk("under.count", 32'(fifo_count), 0);

    // Simultaneous push/pop at count 10.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("pp10.count", 32'(fifo_count), 10);
    chk("pp10.wr_ptr", 32'(wr_ptr), 11);
    chk("pp10.rd_ptr", 32'(rd_ptr), 1);

    // Flush at count 37 with a push in the same cycle.
    for (int i = 0; i < 27; i++) cyc(1, 0, 0, 0);
    chk("pre_flush.count", 32'(fifo_count), 37);
    cyc(1, 0, 1, 0);
    chk("flush.wen", 32'(s_wen), 0);
    chk("flush.wr_ptr", 32'(wr_ptr), 0);
    chk("flush.rd_ptr", 32'(rd_ptr), 0);
    chk("flush.ovf", 32'(overflow), 1);
    chk("flush.unf", 32'(underflow), 1);
    chk_flags("flush", 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    chk("clr.ovf", 32'(overflow), 0);
    chk("clr.unf", 32'(underflow), 0);

    // Async reset between edges at count 80.
    for (int i = 0; i < 80; i++) cyc(1, 0, 0, 0);
    chk("pre_rst.count", 32'(fifo_count), 80);
    push = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_flags("async_rst", 0, 0, 1, 0, 1);
    chk("async_rst.wr_ptr", 32'(wr_ptr), 0);
    chk("async_rst.rd_ptr", 32'(rd_ptr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0, 0);
    chk("post_rst.count", 32'(fifo_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
